lsu_axil_mst: RTL and testbench

Parametrised AXI4-Lite master for core load/store traffic. It sits between the execute stage's memory request and the system AXI4-Lite interconnect. Unlike the previous single-phase bus controller, it has configurable address and data widths and proper write-response tracking. Its registered AW, W, AR, B and R handshakes are independent, and it reports bus errors and, optionally, response timeouts back to the pipeline.

---
 rtl/lsu_axil_mst.sv | 238 +++++++++++++++++++++++
 tb/tb_lsu_axil_mst.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_axil_mst.sv
// lsu_axil_mst: AXI4-Lite master for core load/store traffic.
//
// One transaction is in flight at a time. AW, W and AR valids are registered.
// Each valid drops in the cycle after its own handshake. B and R are always
// accepted (bready = rready = 1). A beat that arrives while no response is
// expected is dropped. Address/data outputs read as zero outside their
// active phase.
//
// Optional feature: define LSU_AXIL_TIMEOUT_EN to abort a B/R wait after
// TO_CYC cycles. The abort completes with rsp_err = 1.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   req_valid/ready/we/addr/wdata/wstrb/abort   core request
//   rsp_valid/rdata/err        one-cycle completion pulse
//   busy                       stall while a transaction is outstanding
//   m_axi_aw*, m_axi_w*, m_axi_b*, m_axi_ar*, m_axi_r*   AXI4-Lite master
//
// States
//   S_IDLE    | waiting for a request; req_ready = 1
//   S_WR_REQ  | AW and/or W still awaiting handshake
//   S_WR_RESP | waiting for B
//   S_RD_REQ  | AR awaiting handshake
//   S_RD_DATA | waiting for R
module lsu_axil_mst #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int TO_CYC = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [AW-1:0]   req_addr,
    input  logic [DW-1:0]   req_wdata,
    input  logic [DW/8-1:0] req_wstrb,
    input  logic            req_abort,
    output logic            rsp_valid,
    output logic [DW-1:0]   rsp_rdata,
    output logic            rsp_err,
    output logic            busy,
    output logic [AW-1:0]   m_axi_awaddr,
    output logic [2:0]      m_axi_awprot,
    output logic            m_axi_awvalid,
    input  logic            m_axi_awready,
    output logic [DW-1:0]   m_axi_wdata,
    output logic [DW/8-1:0] m_axi_wstrb,
    output logic            m_axi_wvalid,
    input  logic            m_axi_wready,
    input  logic [1:0]      m_axi_bresp,
    input  logic            m_axi_bvalid,
    output logic            m_axi_bready,
    output logic [AW-1:0]   m_axi_araddr,
    output logic [2:0]      m_axi_arprot,
    output logic            m_axi_arvalid,
    input  logic            m_axi_arready,
    input  logic [DW-1:0]   m_axi_rdata,
    input  logic [1:0]      m_axi_rresp,
    input  logic            m_axi_rvalid,
    output logic            m_axi_rready
);
    localparam int SW  = DW / 8;
    localparam int OFS = $clog2(SW);
    localparam logic [AW-1:0] ADDR_MASK = {{(AW - OFS){1'b1}}, {OFS{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_DATA
    } state_t;

    state_t          state_q, state_d;
    logic            awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
    logic [AW-1:0]   awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [SW-1:0]   wstrb_q, wstrb_d;
    logic            rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [AW-1:0]   addr_al;

    // Only SLVERR/DECERR matter; the low response bit is don't-care.
    logic unused_resp_lsb;
    assign unused_resp_lsb = ^{m_axi_bresp[0], m_axi_rresp[0]};

    assign addr_al = req_addr & ADDR_MASK;

`ifdef LSU_AXIL_TIMEOUT_EN
    localparam int CW = $clog2(TO_CYC + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TO_CYC - 1);

    logic [CW-1:0] to_cnt_q, to_cnt_d;
    logic          to_expired;

    // Zero in the entry cycle of a wait state, then counts waiting cycles.
    always_comb begin
        to_cnt_d = '0;
        if (state_q == S_WR_RESP || state_q == S_RD_DATA) begin
            to_cnt_d = to_cnt_q + CW'(1);
        end
    end

    assign to_expired = (to_cnt_q == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) to_cnt_q <= '0;
        else        to_cnt_q <= to_cnt_d;
    end
`endif

    always_comb begin
        state_d     = state_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        awaddr_d    = awaddr_q;
        araddr_d    = araddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        case (state_q)
            S_IDLE: begin
                if (req_valid && !req_abort) begin
                    if (req_we) begin
                        state_d   = S_WR_REQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awaddr_d  = addr_al;
                        wdata_d   = req_wdata;
                        wstrb_d   = req_wstrb;
                    end else begin
                        state_d   = S_RD_REQ;
                        arvalid_d = 1'b1;
                        araddr_d  = addr_al;
                    end
                end
            end
            S_WR_REQ: begin
                if (awvalid_q && m_axi_awready) begin
                    awvalid_d = 1'b0;
                    awaddr_d  = '0;
                end
                if (wvalid_q && m_axi_wready) begin
                    wvalid_d = 1'b0;
                    wdata_d  = '0;
                    wstrb_d  = '0;
                end
                // Each channel is done if it already handshook or does so now.
                if ((!awvalid_q || m_axi_awready) && (!wvalid_q || m_axi_wready)) begin
                    state_d = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                if (m_axi_bvalid) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = m_axi_bresp[1];
                end
`ifdef LSU_AXIL_TIMEOUT_EN
                else if (to_expired) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end
`endif
            end
            S_RD_REQ: begin
                if (m_axi_arready) begin
                    state_d   = S_RD_DATA;
                    arvalid_d = 1'b0;
                    araddr_d  = '0;
                end
            end
            S_RD_DATA: begin
                if (m_axi_rvalid) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = m_axi_rdata;
                    rsp_err_d   = m_axi_rresp[1];
                end
`ifdef LSU_AXIL_TIMEOUT_EN
                else if (to_expired) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            awaddr_q    <= awaddr_d;
            araddr_q    <= araddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign req_ready     = (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_err       = rsp_err_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = 1'b1;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = 1'b1;

endmodule

// File: tb/tb_lsu_axil_mst.sv
`timescale 1ns/1ps
module tb_lsu_axil_mst;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO_CYC = 8;
    localparam logic [AW-1:0] ADDR_MASK = ~(AW'(SW - 1));

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic req_valid, req_ready, req_we, req_abort;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [SW-1:0] req_wstrb;
    logic rsp_valid, rsp_err, busy;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
    logic [2:0] m_axi_awprot, m_axi_arprot;
    logic m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [DW-1:0] m_axi_wdata, m_axi_rdata;
    logic [SW-1:0] m_axi_wstrb;
    logic [1:0] m_axi_bresp, m_axi_rresp;
    logic m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic m_axi_rvalid, m_axi_rready;

    always #5 clk = ~clk;

    lsu_axil_mst #(.AW(AW), .DW(DW), .TO_CYC(TO_CYC)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .req_abort(req_abort),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    // One transaction: request fields plus how the slave will behave.
    // r_dly < 0 means the slave never answers the read.
    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic [1:0]    resp;
        int            aw_dly, w_dly, b_dly, ar_dly, r_dly;
    } txn_t;

    typedef struct {
        logic          err;
        logic [DW-1:0] rdata;
        int            t0;
        int            lat;
    } exp_t;

    txn_t slv_q[$];
    exp_t exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int n_rsp = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic txn_t mk(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                input logic [SW-1:0] s, input logic [1:0] resp,
                                input int aw, input int w, input int b, input int ar, input int r);
        txn_t t;
        t.we = we; t.addr = a; t.data = d; t.strb = s; t.resp = resp;
        t.aw_dly = aw; t.w_dly = w; t.b_dly = b; t.ar_dly = ar; t.r_dly = r;
        return t;
    endfunction

    // Cycles from the accept cycle (T0) to the rsp_valid cycle: one cycle to
    // raise valids, the slave's ready delay, one cycle to the response beat,
    // the response delay, one cycle to the registered pulse.
    function automatic int model_lat(input txn_t t);
        if (t.we) return 3 + ((t.aw_dly > t.w_dly) ? t.aw_dly : t.w_dly) + t.b_dly;
        if (t.r_dly < 0) return 2 + t.ar_dly + TO_CYC;
        return 3 + t.ar_dly + t.r_dly;
    endfunction

    task automatic issue(input txn_t t);
        exp_t e;
        int n;
        req_valid = 1'b1; req_abort = 1'b0; req_we = t.we; req_addr = t.addr;
        req_wdata = t.data; req_wstrb = t.strb;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", 64'(req_ready), 1);
        slv_q.push_back(t);
        e.err   = t.we ? t.resp[1] : ((t.r_dly < 0) ? 1'b1 : t.resp[1]);
        e.rdata = (t.we || t.r_dly < 0) ? '0 : t.data;
        e.lat   = model_lat(t);
        e.t0    = cyc;
        exp_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(exp_q.size()), 0);
        @(negedge clk);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 0);
        chk({tag, "_rsp_rdata"}, 64'(rsp_rdata), 0);
        chk({tag, "_rsp_err"}, 64'(rsp_err), 0);
        chk({tag, "_busy"}, 64'(busy), 0);
        chk({tag, "_req_ready"}, 64'(req_ready), 1);
        chk({tag, "_valids"}, 64'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}), 0);
        chk({tag, "_readies"}, 64'({m_axi_bready, m_axi_rready}), 64'h3);
        chk({tag, "_addrs"}, {m_axi_awaddr, m_axi_araddr}, 0);
        chk({tag, "_wdata_wstrb"}, 64'({m_axi_wdata, m_axi_wstrb}), 0);
        chk({tag, "_prot"}, 64'({m_axi_awprot, m_axi_arprot}), 0);
    endtask

    // Response monitor / scoreboard.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid) begin
                n_rsp++;
                chk("rsp_expected", 64'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("rsp_err", 64'(rsp_err), 64'(e.err));
                    chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                    chk("rsp_latency", 64'(cyc - e.t0), 64'(e.lat));
                    chk("ready_in_rsp_cycle", 64'(req_ready), 1);
                end
            end
        end
    end

    // AXI4-Lite slave following the per-transaction behaviour in slv_q.
    initial begin : slave
        txn_t t;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
        m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
        m_axi_rvalid = 1'b0; m_axi_rresp = 2'b00; m_axi_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) continue;
            if (m_axi_arvalid) begin
                chk("slave_cfg_ar", 64'(slv_q.size() != 0), 1);
                if (slv_q.size() == 0) continue;
                t = slv_q.pop_front();
                chk("araddr", 64'(m_axi_araddr), 64'(t.addr & ADDR_MASK));
                chk("arprot", 64'(m_axi_arprot), 0);
                repeat (t.ar_dly) begin
                    chk("arvalid_hold", 64'(m_axi_arvalid), 1);
                    @(negedge clk);
                end
                m_axi_arready = 1'b1;
                @(negedge clk);
                m_axi_arready = 1'b0;
                chk("arvalid_drop", 64'(m_axi_arvalid), 0);
                chk("araddr_idle", 64'(m_axi_araddr), 0);
                if (t.r_dly >= 0) begin
                    repeat (t.r_dly) @(negedge clk);
                    m_axi_rvalid = 1'b1; m_axi_rdata = t.data; m_axi_rresp = t.resp;
                    @(negedge clk);
                    m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = 2'b00;
                end else begin
                    // No answer; a late stray beat follows once the master is idle.
                    repeat (TO_CYC + 3) @(negedge clk);
                    m_axi_rvalid = 1'b1; m_axi_rdata = DW'($urandom); m_axi_rresp = 2'b00;
                    @(negedge clk);
                    m_axi_rvalid = 1'b0; m_axi_rdata = '0;
                end
            end else if (m_axi_awvalid || m_axi_wvalid) begin
                chk("slave_cfg_aw", 64'(slv_q.size() != 0), 1);
                if (slv_q.size() == 0) continue;
                t = slv_q.pop_front();
                chk("aw_w_together", 64'({m_axi_awvalid, m_axi_wvalid}), 64'h3);
                chk("awaddr", 64'(m_axi_awaddr), 64'(t.addr & ADDR_MASK));
                chk("awprot", 64'(m_axi_awprot), 0);
                chk("wdata", 64'(m_axi_wdata), 64'(t.data));
                chk("wstrb", 64'(m_axi_wstrb), 64'(t.strb));
                fork
                    begin
                        repeat (t.aw_dly) begin
                            chk("awvalid_hold", 64'(m_axi_awvalid), 1);
                            @(negedge clk);
                        end
                        m_axi_awready = 1'b1;
                        @(negedge clk);
                        m_axi_awready = 1'b0;
                        chk("awvalid_drop", 64'(m_axi_awvalid), 0);
                        chk("awaddr_idle", 64'(m_axi_awaddr), 0);
                    end
                    begin
                        repeat (t.w_dly) begin
                            chk("wvalid_hold", 64'(m_axi_wvalid), 1);
                            @(negedge clk);
                        end
                        m_axi_wready = 1'b1;
                        @(negedge clk);
                        m_axi_wready = 1'b0;
                        chk("wvalid_drop", 64'(m_axi_wvalid), 0);
                        chk("wdata_idle", 64'({m_axi_wdata, m_axi_wstrb}), 0);
                    end
                join
                repeat (t.b_dly) @(negedge clk);
                m_axi_bvalid = 1'b1; m_axi_bresp = t.resp;
                @(negedge clk);
                m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        txn_t t;
        int n0;
        req_valid = 1'b0; req_abort = 1'b0; req_we = 1'b0;
        req_addr = '0; req_wdata = '0; req_wstrb = '0;
        #1 rst_n = 1'b0;
        #2 chk_reset("por");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Zero-wait load, unaligned address.
        issue(mk(1'b0, 32'h0000_1003, 32'hDEAD_BEEF, '0, 2'b00, 0, 0, 0, 0, 0));
        drain();

        // Store with split AW/W handshakes and delayed B.
        issue(mk(1'b1, 32'h0000_2004, 32'h1234_5678, 4'b0011, 2'b00, 0, 2, 1, 0, 0));
        drain();

        // Error load followed by a back-to-back load.
        issue(mk(1'b0, 32'h0000_3008, 32'hCAFE_F00D, '0, 2'b10, 0, 0, 0, 0, 0));
        issue(mk(1'b0, 32'h0000_300C, 32'h0BAD_F00D, '0, 2'b00, 0, 0, 0, 1, 0));
        drain();

        // Request held off by req_abort for three cycles.
        t = mk(1'b0, 32'h0000_4000, 32'h5555_AAAA, '0, 2'b00, 0, 0, 0, 0, 0);
        req_valid = 1'b1; req_abort = 1'b1; req_we = 1'b0; req_addr = t.addr;
        repeat (3) begin
            @(negedge clk);
            chk("abort_busy", 64'(busy), 0);
            chk("abort_valids", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}), 0);
        end
        req_abort = 1'b0;
        slv_q.push_back(t);
        exp_q.push_back('{err: 1'b0, rdata: t.data, t0: cyc, lat: model_lat(t)});
        @(negedge clk);
        chk("arvalid_after_abort", 64'(m_axi_arvalid), 1);
        req_valid = 1'b0; req_addr = '0;
        drain();

        // Responses landing on the last cycle before a timeout would fire.
        issue(mk(1'b0, 32'h0000_6000, 32'h7777_1111, '0, 2'b00, 0, 0, 0, 0, TO_CYC - 1));
        issue(mk(1'b1, 32'h0000_6004, 32'h8888_2222, 4'hF, 2'b11, 0, 0, TO_CYC - 1, 0, 0));
        drain();

`ifdef LSU_AXIL_TIMEOUT_EN
        issue(mk(1'b0, 32'h0000_5000, 32'h1357_9BDF, '0, 2'b00, 0, 0, 0, 0, -1));
        drain();
        n0 = n_rsp;
        repeat (TO_CYC + 8) @(negedge clk);
        chk("stray_r_discarded", 64'(n_rsp), 64'(n0));
        chk("idle_after_stray", 64'(busy), 0);
`endif

        // Reset while waiting for B; the late B beat must be ignored.
        issue(mk(1'b1, 32'h0000_7000, 32'hA5A5_A5A5, 4'hF, 2'b00, 0, 0, 12, 0, 0));
        @(negedge clk);
        chk("busy_before_reset", 64'(busy), 1);
        n0 = n_rsp;
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1 chk_reset("mid");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("no_rsp_after_reset", 64'(n_rsp), 64'(n0));
        issue(mk(1'b1, 32'h0000_7010, 32'h0F0F_0F0F, 4'b1100, 2'b00, 1, 0, 0, 0, 0));
        drain();

        // Randomised traffic.
        for (int i = 0; i < 80; i++) begin
            t = mk(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
                   SW'($urandom_range(0, (1 << SW) - 1)), 2'($urandom_range(0, 3)),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3));
            issue(t);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();
        chk("slave_queue_empty", 64'(slv_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
